// File: rtl/cdl_lock_ctrl_if.sv
// Control and status bundle between the coarse delay-line lock controller and its environment.
interface cdl_lock_ctrl_if;
    logic        en;
    logic        pd_up;
    logic        pd_dn;
    logic        fine_up;
    logic        fine_dn;
    logic [15:0] T;
    logic [15:0] Tb;
    logic [3:0]  sel;
    logic        locked;
    logic        busy;
    logic        sat;

    modport master (
        output en, pd_up, pd_dn, fine_up, fine_dn,
        input  T, Tb, sel, locked, busy, sat
    );

    modport slave (
        input  en, pd_up, pd_dn, fine_up, fine_dn,
        output T, Tb, sel, locked, busy, sat
    );
endinterface

// File: rtl/cdl_lock_ctrl.sv
// Coarse delay-line lock controller: walks a 16-stage thermometer code from phase-detector
// decisions until the direction keeps reversing, then tracks fine-line overflow/underflow.
module cdl_lock_ctrl #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned LOCK_CNT   = 6
) (
    input logic           clk,
    input logic           rst,
    cdl_lock_ctrl_if.slave bus
);
    localparam int unsigned STAGES = 16;
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [3:0]  LOCK_TGT    = 4'(LOCK_CNT);
    localparam logic [3:0]  SEL_MAX     = 4'(STAGES - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, LOCKED, HOLD} state_t;

    state_t      state;
    logic [3:0]  sel_q;
    logic [3:0]  cnt_q;
    logic [3:0]  rev_q;
    logic        dir_up_q;
    logic        have_dir_q;
    logic [15:0] t_q;
    logic [15:0] tb_q;
    logic        locked_q;
    logic        busy_q;
    logic        sat_q;

    logic        req_up_c;
    logic        req_dn_c;
    logic        blocked_c;
    logic        moved_c;
    logic [3:0]  sel_step_c;
    logic [3:0]  rev_next_c;

    function automatic logic [15:0] therm(input logic [3:0] s);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = (4'(i) < s);
        return t;
    endfunction

    // Step request: phase detector while sampling, fine-line carry while locked.
    always_comb begin
        req_up_c = 1'b0;
        req_dn_c = 1'b0;
        if (state == SAMPLE) begin
            req_up_c = bus.pd_up & ~bus.pd_dn;
            req_dn_c = bus.pd_dn & ~bus.pd_up;
        end else if (state == LOCKED) begin
            req_up_c = bus.fine_up & ~bus.fine_dn;
            req_dn_c = bus.fine_dn & ~bus.fine_up;
        end
        blocked_c  = (req_up_c && sel_q == SEL_MAX) || (req_dn_c && sel_q == 4'd0);
        moved_c    = (req_up_c | req_dn_c) & ~blocked_c;
        sel_step_c = req_up_c ? sel_q + 4'd1 : sel_q - 4'd1;
        rev_next_c = 4'd0;
        if (moved_c && have_dir_q && (dir_up_q != req_up_c)) rev_next_c = rev_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= 4'd0;
            cnt_q      <= 4'd0;
            rev_q      <= 4'd0;
            dir_up_q   <= 1'b0;
            have_dir_q <= 1'b0;
            t_q        <= 16'h0000;
            tb_q       <= 16'hFFFF;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else if (!bus.en) begin
            // Drop back to idle but keep the code so re-acquisition resumes from here.
            state      <= IDLE;
            cnt_q      <= 4'd0;
            rev_q      <= 4'd0;
            have_dir_q <= 1'b0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            if (moved_c) begin
                sel_q <= sel_step_c;
                t_q   <= therm(sel_step_c);
                tb_q  <= ~therm(sel_step_c);
                sat_q <= 1'b0;
            end else if (blocked_c) begin
                sat_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    cnt_q      <= SETTLE_LOAD;
                    have_dir_q <= 1'b0;
                    rev_q      <= 4'd0;
                    busy_q     <= 1'b1;
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) state <= SAMPLE;
                    else               cnt_q <= cnt_q - 4'd1;
                end
                SAMPLE: begin
                    rev_q <= rev_next_c;
                    if (moved_c) begin
                        dir_up_q   <= req_up_c;
                        have_dir_q <= 1'b1;
                    end
                    if (rev_next_c == LOCK_TGT) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        state <= SETTLE;
                        cnt_q <= SETTLE_LOAD;
                    end
                end
                LOCKED: begin
                    if (moved_c) begin
                        state  <= HOLD;
                        cnt_q  <= SETTLE_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == 4'd0) begin
                        state  <= LOCKED;
                        busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.T      = t_q;
    assign bus.Tb     = tb_q;
    assign bus.sel    = sel_q;
    assign bus.locked = locked_q;
    assign bus.busy   = busy_q;
    assign bus.sat    = sat_q;
endmodule

// File: tb/tb_cdl_lock_ctrl.sv
// Scoreboard bench for cdl_lock_ctrl: a timing-level reference model predicts every cycle's outputs.
module tb_cdl_lock_ctrl;
    localparam int S = 4;
    localparam int L = 6;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] t;
        logic [15:0] tb;
        logic        locked;
        logic        busy;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdl_lock_ctrl_if bus ();
    cdl_lock_ctrl #(.SETTLE_CYC(S), .LOCK_CNT(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Reference model: position inside a settle+sample frame, hold countdown, code value.
    bit m_run, m_locked, m_sat;
    int m_pos, m_hold, m_sel, m_rev, m_last;

    function automatic exp_t model_out();
        exp_t        e;
        logic [31:0] th;
        th       = (32'd1 << m_sel) - 32'd1;
        e.sel    = 4'(m_sel);
        e.t      = th[15:0];
        e.tb     = ~th[15:0];
        e.locked = m_locked;
        e.busy   = m_run || (m_hold > 0);
        e.sat    = m_sat;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t g;
        g.sel = bus.sel; g.t = bus.T; g.tb = bus.Tb;
        g.locked = bus.locked; g.busy = bus.busy; g.sat = bus.sat;
        return g;
    endfunction

    task automatic model_reset();
        m_run = 0; m_locked = 0; m_sat = 0;
        m_pos = 0; m_hold = 0; m_sel = 0; m_rev = 0; m_last = 0;
    endtask

    task automatic try_move(input int dir, output bit ok);
        int t;
        t = m_sel + dir;
        if (t < 0 || t > 15) begin
            m_sat = 1; ok = 0;
        end else begin
            m_sel = t; m_sat = 0; ok = 1;
        end
    endtask

    task automatic model_edge(input bit e, input bit u, input bit d, input bit fu, input bit fd);
        bit ok;
        int dir;
        if (!e) begin
            m_run = 0; m_locked = 0; m_hold = 0; m_sat = 0; m_rev = 0; m_last = 0;
        end else if (m_locked) begin
            if (m_hold > 0) m_hold--;
            else if (fu != fd) begin
                try_move(fu ? 1 : -1, ok);
                if (ok) m_hold = S;
            end
        end else if (!m_run) begin
            m_run = 1; m_pos = 1; m_last = 0; m_rev = 0;
        end else if (m_pos <= S) begin
            m_pos++;
        end else begin
            dir = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
            ok  = 0;
            if (dir != 0) try_move(dir, ok);
            if (ok) begin
                m_rev  = (m_last == -dir) ? m_rev + 1 : 0;
                m_last = dir;
            end else begin
                m_rev = 0;
            end
            if (m_rev == L) begin
                m_locked = 1; m_run = 0;
            end else begin
                m_pos = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got sel=%0d T=%h Tb=%h lk=%b bz=%b sat=%b, expected sel=%0d T=%h Tb=%h lk=%b bz=%b sat=%b",
                     nm, $time, got.sel, got.t, got.tb, got.locked, got.busy, got.sat,
                     want.sel, want.t, want.tb, want.locked, want.busy, want.sat);
        end
    endtask

    task automatic chk_val(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, got, want);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then queue the predicted outputs.
    task automatic step_cyc(input bit e, input bit u, input bit d, input bit fu, input bit fd);
        bus.en = e; bus.pd_up = u; bus.pd_dn = d; bus.fine_up = fu; bus.fine_dn = fd;
        @(posedge clk);
        model_edge(e, u, d, fu, fd);
        exp_q.push_back(model_out());
        #1;
    endtask

    // Mid-cycle reset: outputs must clear without waiting for a clock edge.
    task automatic async_reset(input bit u, input bit d);
        bus.en = 1; bus.pd_up = u; bus.pd_dn = d; bus.fine_up = 0; bus.fine_dn = 0;
        #2;
        rst = 1;
        exp_q.delete();
        model_reset();
        #1;
        chk("async_rst", dut_out(), model_out());
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold", dut_out(), model_out());
        end
        rst = 0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("cycle", dut_out(), exp_q.pop_front());
    end

    initial begin
        int guard;
        int r;
        bit u, d;
        exp_t rst_exp;
        model_reset();
        bus.en = 0; bus.pd_up = 0; bus.pd_dn = 0; bus.fine_up = 0; bus.fine_dn = 0;
        rst_exp = '{sel: 4'd0, t: 16'h0000, tb: 16'hFFFF, locked: 1'b0, busy: 1'b0, sat: 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vals", dut_out(), rst_exp);
        rst = 0;

        // Upward walk to the top of the code, then beyond it.
        for (int i = 0; i < 100; i++) step_cyc(1, 1, 0, 0, 0);
        chk_val("top_T", int'(bus.T), 32'h7FFF);
        chk_val("top_sat", int'(bus.sat), 1);
        // Downward walk to zero and beyond.
        for (int i = 0; i < 100; i++) step_cyc(1, 0, 1, 0, 0);
        chk_val("bottom_T", int'(bus.T), 0);
        chk_val("bottom_sat", int'(bus.sat), 1);

        // Reach sel=8, restart from idle, then alternate until lock.
        guard = 0;
        while (m_sel != 8 && guard < 200) begin step_cyc(1, m_sel < 8, m_sel > 8, 0, 0); guard++; end
        step_cyc(0, 0, 0, 0, 0);
        guard = 0;
        while (!m_locked && guard < 60) begin step_cyc(1, m_sel == 8, m_sel != 8, 0, 0); guard++; end
        chk_val("lock_rise", int'(bus.locked), 1);
        chk_val("lock_sel", int'(bus.sel), 9);

        // Fine tracking: step down, ignored requests during hold, step up, simultaneous pulses.
        step_cyc(1, 1, 0, 0, 1);
        step_cyc(1, 0, 0, 0, 0);
        step_cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step_cyc(1, 0, 0, 0, 0);
        chk_val("fine_dn_sel", int'(bus.sel), 8);
        step_cyc(1, 0, 1, 1, 0);
        chk_val("hold_busy", int'(bus.busy), 1);
        step_cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step_cyc(1, 0, 0, 0, 0);
        chk_val("fine_up_sel", int'(bus.sel), 9);
        step_cyc(1, 0, 0, 1, 1);
        step_cyc(1, 0, 0, 0, 0);

        // Drop enable while locked, then re-acquire from the retained code.
        step_cyc(0, 0, 0, 0, 0);
        chk_val("en_off_locked", int'(bus.locked), 0);
        chk_val("en_off_sel", int'(bus.sel), 9);
        for (int i = 0; i < 12; i++) step_cyc(1, 1, 0, 0, 0);

        // Park at sel=5, reset in the middle of a settle window with both pd inputs high.
        step_cyc(0, 0, 0, 0, 0);
        guard = 0;
        while (m_sel != 5 && guard < 200) begin step_cyc(1, m_sel < 5, m_sel > 5, 0, 0); guard++; end
        guard = 0;
        while (!(m_run && m_pos == 2) && guard < 20) begin step_cyc(1, 1, 1, 0, 0); guard++; end
        async_reset(1, 1);
        for (int i = 0; i < 20; i++) step_cyc(1, 1, 1, 0, 0);
        chk_val("both_pd_sel", int'(bus.sel), 0);

        // Randomized traffic, biased toward reversals so lock and fine tracking get exercised.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end else begin
                r = int'($urandom_range(0, 9));
                if (r <= 5) begin
                    if (m_last == 0) begin u = $urandom_range(0, 1) == 1; d = !u; end
                    else begin u = (m_last < 0); d = (m_last > 0); end
                end else if (r <= 7) begin
                    u = (m_last >= 0); d = (m_last < 0);
                end else begin
                    u = (r == 9); d = (r == 9);
                end
                step_cyc($urandom_range(0, 63) != 0, u, d,
                         $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end
        end

        @(negedge clk);
        #1;
        chk_val("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
